mem_controller: RTL and testbench

MEM_CONTROLLER -- requirements
Module: mem_controller

---
 rtl/mem_controller_pkg.sv | 40 ++++
 rtl/mem_controller_load_extend.sv | 23 ++
 rtl/mem_controller.sv | 150 +++++++++++++++
 tb/tb_mem_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_controller_pkg.sv
// Shared memory-interface constants: LSB op codes, UART IO addresses,
// the latched-request record and small decode helpers.
package mem_controller_pkg;

  // LSB memory op codes
  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;
  localparam logic [5:0] OP_SW  = 6'd18;

  // Memory-mapped UART addresses; stores here wait while the TX buffer is full
  localparam logic [31:0] IO_ADDR_0 = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_1 = 32'h0003_0004;

  // Everything captured when a transaction is accepted
  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  len;
  } req_t;

  // Access length in bytes for an op code
  function automatic logic [2:0] op_len(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
      default:              op_len = 3'd4;
    endcase
  endfunction

  function automatic logic is_io_addr(input logic [31:0] addr);
    is_io_addr = (addr == IO_ADDR_0) || (addr == IO_ADDR_1);
  endfunction

endpackage

// File: rtl/mem_controller_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module mem_controller_load_extend
  import mem_controller_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [31:0] i_word,
  output logic [31:0] o_val
);

  // Pick the extension rule for the load width
  always_comb begin
    // NOTE: o_val is assigned before the case so no path leaves it unassigned and no latch is inferred.
    o_val = i_word;
    case (i_op)
      OP_LB:   o_val = {{24{i_word[7]}}, i_word[7:0]};
      OP_LH:   o_val = {{16{i_word[15]}}, i_word[15:0]};
      OP_LBU:  o_val = {24'd0, i_word[7:0]};
      OP_LHU:  o_val = {16'd0, i_word[15:0]};
      default: o_val = i_word;
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// Byte-serial memory controller arbitrating LSB loads/stores and
// instruction fetches onto an 8-bit RAM port with one-cycle read latency.
module mem_controller
  import mem_controller_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        lsb_clear,
  input  logic        request,
  input  logic        load_or_store,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_valid,
  output logic [31:0] mem_val,
  input  logic        if_request,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_STORE = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_cnt;       // byte index; in reads it runs to len+1 (pulse cycle)
  req_t        r_req;
  logic [31:0] r_buf;       // bytes assembled so far
  logic        r_mem_valid;
  logic        r_if_valid;
  logic [31:0] r_mem_val;
  logic [31:0] r_if_inst;

  logic [31:0] w_word;      // r_buf with the byte arriving this cycle merged in
  logic [31:0] w_ext;
  logic        w_write_phase;
  logic        w_stall;

  mem_controller_load_extend u_load_extend (
    .i_op   (r_req.op),
    .i_word (w_word),
    .o_val  (w_ext)
  );

  // Merge the returning RAM byte (belonging to index r_cnt-1) into the buffer
  always_comb begin
    w_word = r_buf;
    case (r_cnt[1:0])
      2'd1:    w_word[7:0]   = mem_din;
      2'd2:    w_word[15:8]  = mem_din;
      2'd3:    w_word[23:16] = mem_din;
      default: w_word[31:24] = mem_din;
    endcase
  end

  // RAM port: address walks from the base, store byte follows the counter
  always_comb begin
    mem_a         = r_req.addr + {29'd0, r_cnt};
    w_write_phase = (r_state == ST_STORE) && (r_cnt < r_req.len);
    w_stall       = is_io_addr(r_req.addr) && io_buffer_full;
    mem_wr        = w_write_phase && !w_stall;
    case (r_cnt[1:0])
      2'd0:    mem_dout = r_req.data[7:0];
      2'd1:    mem_dout = r_req.data[15:8];
      2'd2:    mem_dout = r_req.data[23:16];
      default: mem_dout = r_req.data[31:24];
    endcase
  end

  assign mem_valid = r_mem_valid;
  assign if_valid  = r_if_valid;
  assign mem_val   = r_mem_val;
  assign if_inst   = r_if_inst;

  // Transaction FSM: accept, walk bytes, pulse completion, one DONE cycle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_req       <= '0;
      r_buf       <= 32'd0;
      r_mem_valid <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_val   <= 32'd0;
      r_if_inst   <= 32'd0;
    end else if (rdy_in) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values regardless of statement order.
      r_mem_valid <= 1'b0;
      r_if_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!lsb_clear) begin
            if (request) begin
              r_req   <= '{op: mem_op, addr: mem_addr, data: mem_data, len: op_len(mem_op)};
              r_cnt   <= 3'd0;
              r_state <= load_or_store ? ST_STORE : ST_LOAD;
            end else if (if_request) begin
              r_req   <= '{op: 6'd0, addr: if_addr, data: 32'd0, len: 3'd4};
              r_cnt   <= 3'd0;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_LOAD, ST_FETCH: begin
          if (lsb_clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
          end else if (r_cnt == r_req.len + 3'd1) begin
            r_state <= ST_DONE;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt != 3'd0) r_buf <= w_word;
            if (r_cnt == r_req.len) begin
              if (r_state == ST_LOAD) begin
                r_mem_valid <= 1'b1;
                r_mem_val   <= w_ext;
              end else begin
                r_if_valid <= 1'b1;
                r_if_inst  <= w_word;
              end
            end
          end
        end
        ST_STORE: begin
          // A store is already committed, so lsb_clear is deliberately ignored
          if (r_cnt == r_req.len) begin
            r_state <= ST_DONE;
            r_cnt   <= 3'd0;
          end else if (!w_stall) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == r_req.len - 3'd1) r_mem_valid <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a byte RAM model and write log.
module tb_mem_controller;
  import mem_controller_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        lsb_clear = 1'b0;
  logic        request = 1'b0;
  logic        load_or_store = 1'b0;
  logic [5:0]  mem_op = 6'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic        mem_valid;
  logic [31:0] mem_val;
  logic        if_request = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int mv_cnt = 0;
  int iv_cnt = 0;
  bit both_seen = 1'b0;

  logic [7:0]  ram [0:4095];
  logic [31:0] wr_a_q [$];
  logic [7:0]  wr_d_q [$];
  int          wr_c_q [$];

  mem_controller dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .lsb_clear(lsb_clear),
    .request(request), .load_or_store(load_or_store), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid), .mem_val(mem_val),
    .if_request(if_request), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: read data one cycle after the address, writes logged with cycle
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) begin
      ram[mem_a[11:0]] = mem_dout;
      wr_a_q.push_back(mem_a);
      wr_d_q.push_back(mem_dout);
      wr_c_q.push_back(cyc);
    end
  end

  // Pulse monitor on the falling edge
  always @(negedge clk_in) begin
    if (mem_valid) mv_cnt = mv_cnt + 1;
    if (if_valid) iv_cnt = iv_cnt + 1;
    if (mem_valid && if_valid) both_seen = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Issue one LSB access, wait (bounded) for mem_valid, hold request 'hold' more cycles
  task automatic lsb_access(input logic [5:0] op, input logic st, input logic [31:0] a,
                            input logic [31:0] d, input int hold,
                            output bit got, output int lat, output logic [31:0] val);
    int t0;
    @(negedge clk_in);
    request = 1'b1; load_or_store = st; mem_op = op; mem_addr = a; mem_data = d;
    t0 = cyc; got = 1'b0; lat = -1; val = 32'd0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_in);
      if (mem_valid) begin got = 1'b1; lat = cyc - t0; val = mem_val; end
    end
    repeat (hold) @(negedge clk_in);
    request = 1'b0;
  endtask

  task automatic test_reset;
    idle(2);
    n_vec++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    n_vec++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
    n_vec++; if (mem_val !== 32'd0) begin n_bad++; $display("FAIL rst_mem_val: got %h want 0", mem_val); end
    n_vec++; if (if_inst !== 32'd0) begin n_bad++; $display("FAIL rst_if_inst: got %h want 0", if_inst); end
    n_vec++; if (mem_a !== 32'd0) begin n_bad++; $display("FAIL rst_mem_a: got %h want 0", mem_a); end
    n_vec++; if (mem_dout !== 8'd0) begin n_bad++; $display("FAIL rst_mem_dout: got %h want 0", mem_dout); end
    rst_in = 1'b1;
    idle(2);
  endtask

  task automatic test_lw;
    bit got; int lat; logic [31:0] val; int n0; int mv0;
    n0 = wr_a_q.size(); mv0 = mv_cnt;
    lsb_access(OP_LW, 1'b0, 32'h100, 32'd0, 0, got, lat, val);
    idle(3);
    n_vec++; if (got !== 1'b1) begin n_bad++; $display("FAIL lw_pulse: got %b want 1", got); end
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL lw_latency: got %0d want 6", lat); end
    n_vec++; if (val !== 32'h4433_2211) begin n_bad++; $display("FAIL lw_value: got %h want 44332211", val); end
    n_vec++; if (wr_a_q.size() !== n0) begin n_bad++; $display("FAIL lw_no_write: got %0d writes want 0", wr_a_q.size() - n0); end
    n_vec++; if (mv_cnt - mv0 !== 1) begin n_bad++; $display("FAIL lw_pulse_count: got %0d want 1", mv_cnt - mv0); end
  endtask

  task automatic test_extend;
    bit got; int lat; logic [31:0] val;
    lsb_access(OP_LB, 1'b0, 32'h200, 32'd0, 0, got, lat, val); idle(2);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL lb_latency: got %0d want 3", lat); end
    n_vec++; if (val !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_value: got %h want ffffff80", val); end
    lsb_access(OP_LBU, 1'b0, 32'h200, 32'd0, 0, got, lat, val); idle(2);
    n_vec++; if (val !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_value: got %h want 00000080", val); end
    lsb_access(OP_LH, 1'b0, 32'h202, 32'd0, 0, got, lat, val); idle(2);
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL lh_latency: got %0d want 4", lat); end
    n_vec++; if (val !== 32'hFFFF_9234) begin n_bad++; $display("FAIL lh_value: got %h want ffff9234", val); end
    lsb_access(OP_LHU, 1'b0, 32'h202, 32'd0, 0, got, lat, val); idle(2);
    n_vec++; if (val !== 32'h0000_9234) begin n_bad++; $display("FAIL lhu_value: got %h want 00009234", val); end
    lsb_access(OP_LB, 1'b0, 32'h204, 32'd0, 0, got, lat, val); idle(2);
    n_vec++; if (val !== 32'h0000_007F) begin n_bad++; $display("FAIL lb_pos_value: got %h want 0000007f", val); end
    lsb_access(OP_LW, 1'b0, 32'hFFFF_FFFE, 32'd0, 0, got, lat, val); idle(2);
    n_vec++; if (val !== 32'hD4C3_B2A1) begin n_bad++; $display("FAIL lw_wrap_value: got %h want d4c3b2a1", val); end
  endtask

  task automatic test_store;
    bit got; int lat; logic [31:0] val; int n0; logic [31:0] word;
    n0 = wr_a_q.size();
    lsb_access(OP_SH, 1'b1, 32'h10, 32'h0000_ABCD, 0, got, lat, val); idle(2);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sh_latency: got %0d want 3", lat); end
    n_vec++; if (wr_a_q.size() - n0 !== 2) begin n_bad++; $display("FAIL sh_write_count: got %0d want 2", wr_a_q.size() - n0); end
    if (wr_a_q.size() - n0 >= 2) begin
      n_vec++; if (wr_a_q[n0] !== 32'h10 || wr_d_q[n0] !== 8'hCD) begin n_bad++; $display("FAIL sh_byte0: got %h<=%h want 10<=cd", wr_a_q[n0], wr_d_q[n0]); end
      n_vec++; if (wr_a_q[n0+1] !== 32'h11 || wr_d_q[n0+1] !== 8'hAB) begin n_bad++; $display("FAIL sh_byte1: got %h<=%h want 11<=ab", wr_a_q[n0+1], wr_d_q[n0+1]); end
      n_vec++; if (wr_c_q[n0+1] - wr_c_q[n0] !== 1) begin n_bad++; $display("FAIL sh_consecutive: got gap %0d want 1", wr_c_q[n0+1] - wr_c_q[n0]); end
    end
    lsb_access(OP_SW, 1'b1, 32'h20, 32'hDEAD_BEEF, 0, got, lat, val); idle(2);
    word = {ram[12'h023], ram[12'h022], ram[12'h021], ram[12'h020]};
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL sw_latency: got %0d want 5", lat); end
    n_vec++; if (word !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_ram: got %h want deadbeef", word); end
    lsb_access(OP_LW, 1'b0, 32'h20, 32'd0, 0, got, lat, val); idle(2);
    n_vec++; if (val !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_readback: got %h want deadbeef", val); end
  endtask

  task automatic test_priority;
    int t0; int tm; int ti; int mv0; int iv0; int iv_at_m; bit gm; bit gi; logic [31:0] vm; logic [31:0] inst;
    mv0 = mv_cnt; iv0 = iv_cnt; tm = -1; ti = -1; gm = 1'b0; gi = 1'b0; vm = 32'd0; inst = 32'd0; iv_at_m = -1;
    @(negedge clk_in);
    request = 1'b1; load_or_store = 1'b0; mem_op = OP_LW; mem_addr = 32'h100;
    if_request = 1'b1; if_addr = 32'h104; t0 = cyc;
    for (int i = 0; i < 40 && !gm; i++) begin
      @(negedge clk_in);
      if (mem_valid) begin gm = 1'b1; tm = cyc; vm = mem_val; iv_at_m = iv_cnt; end
    end
    @(negedge clk_in);
    request = 1'b0;
    for (int i = 0; i < 40 && !gi; i++) begin
      @(negedge clk_in);
      if (if_valid) begin gi = 1'b1; ti = cyc; inst = if_inst; end
    end
    if_request = 1'b0;
    idle(8);
    n_vec++; if (tm - t0 !== 6) begin n_bad++; $display("FAIL prio_lsb_latency: got %0d want 6", tm - t0); end
    n_vec++; if (vm !== 32'h4433_2211) begin n_bad++; $display("FAIL prio_lsb_value: got %h want 44332211", vm); end
    n_vec++; if (iv_at_m !== iv0) begin n_bad++; $display("FAIL prio_if_before_lsb: got %0d fetches want 0", iv_at_m - iv0); end
    n_vec++; if (ti - tm !== 8) begin n_bad++; $display("FAIL prio_if_gap: got %0d want 8", ti - tm); end
    n_vec++; if (inst !== 32'h1234_5678) begin n_bad++; $display("FAIL prio_if_inst: got %h want 12345678", inst); end
    n_vec++; if (mv_cnt - mv0 !== 1) begin n_bad++; $display("FAIL prio_single_valid: got %0d want 1", mv_cnt - mv0); end
    n_vec++; if (iv_cnt - iv0 !== 1) begin n_bad++; $display("FAIL prio_single_fetch: got %0d want 1", iv_cnt - iv0); end
  endtask

  task automatic test_io_stall;
    bit got; int lat; logic [31:0] val; int t0; int n0; int mv0; int sw; int sp;
    n0 = wr_a_q.size(); mv0 = mv_cnt; got = 1'b0; lat = -1;
    @(negedge clk_in);
    io_buffer_full = 1'b1;
    request = 1'b1; load_or_store = 1'b1; mem_op = OP_SB; mem_addr = 32'h0003_0000; mem_data = 32'h0000_005A;
    t0 = cyc;
    repeat (5) @(negedge clk_in);
    sw = wr_a_q.size() - n0; sp = mv_cnt - mv0;
    io_buffer_full = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_in);
      if (mem_valid) begin got = 1'b1; lat = cyc - t0; end
    end
    request = 1'b0;
    idle(2);
    n_vec++; if (sw !== 0) begin n_bad++; $display("FAIL io_write_during_stall: got %0d want 0", sw); end
    n_vec++; if (sp !== 0) begin n_bad++; $display("FAIL io_pulse_during_stall: got %0d want 0", sp); end
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL io_latency: got %0d want 6", lat); end
    n_vec++; if (wr_a_q.size() - n0 !== 1) begin n_bad++; $display("FAIL io_write_count: got %0d want 1", wr_a_q.size() - n0); end
    if (wr_a_q.size() - n0 >= 1) begin
      n_vec++; if (wr_a_q[n0] !== 32'h0003_0000 || wr_d_q[n0] !== 8'h5A) begin n_bad++; $display("FAIL io_write: got %h<=%h want 30000<=5a", wr_a_q[n0], wr_d_q[n0]); end
      n_vec++; if (wr_c_q[n0] !== t0 + 5) begin n_bad++; $display("FAIL io_write_cycle: got %0d want %0d", wr_c_q[n0], t0 + 5); end
    end
    // Non-IO store is unaffected by a full UART buffer
    io_buffer_full = 1'b1;
    lsb_access(OP_SB, 1'b1, 32'h40, 32'h0000_0077, 0, got, lat, val);
    io_buffer_full = 1'b0;
    idle(2);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL non_io_latency: got %0d want 2", lat); end
    n_vec++; if (ram[12'h040] !== 8'h77) begin n_bad++; $display("FAIL non_io_ram: got %h want 77", ram[12'h040]); end
  endtask

  task automatic test_clear;
    int t0; int c; int ti; int mv0; int n0; int lat; bit gi; bit gm; logic [31:0] inst; logic [31:0] val; logic [31:0] word;
    // Abort a load; a fetch raised alongside is accepted the very next cycle
    mv0 = mv_cnt; gi = 1'b0; ti = -1; inst = 32'd0;
    @(negedge clk_in);
    request = 1'b1; load_or_store = 1'b0; mem_op = OP_LW; mem_addr = 32'h100;
    repeat (3) @(negedge clk_in);
    lsb_clear = 1'b1; request = 1'b0; if_request = 1'b1; if_addr = 32'h100; c = cyc;
    @(negedge clk_in);
    lsb_clear = 1'b0;
    for (int i = 0; i < 40 && !gi; i++) begin
      @(negedge clk_in);
      if (if_valid) begin gi = 1'b1; ti = cyc; inst = if_inst; end
    end
    if_request = 1'b0;
    idle(6);
    n_vec++; if (mv_cnt !== mv0) begin n_bad++; $display("FAIL clear_load_pulse: got %0d want 0", mv_cnt - mv0); end
    n_vec++; if (ti - c !== 7) begin n_bad++; $display("FAIL clear_idle_next: got %0d want 7", ti - c); end
    n_vec++; if (inst !== 32'h4433_2211) begin n_bad++; $display("FAIL clear_fetch_inst: got %h want 44332211", inst); end
    // Clear during a store is ignored
    n0 = wr_a_q.size(); gm = 1'b0; lat = -1;
    @(negedge clk_in);
    request = 1'b1; load_or_store = 1'b1; mem_op = OP_SW; mem_addr = 32'h40; mem_data = 32'h1122_3344; t0 = cyc;
    repeat (2) @(negedge clk_in);
    lsb_clear = 1'b1;
    @(negedge clk_in);
    lsb_clear = 1'b0;
    for (int i = 0; i < 40 && !gm; i++) begin
      @(negedge clk_in);
      if (mem_valid) begin gm = 1'b1; lat = cyc - t0; end
    end
    request = 1'b0;
    idle(2);
    word = {ram[12'h043], ram[12'h042], ram[12'h041], ram[12'h040]};
    n_vec++; if (lat !== 5) begin n_bad++; $display("FAIL clear_store_latency: got %0d want 5", lat); end
    n_vec++; if (wr_a_q.size() - n0 !== 4) begin n_bad++; $display("FAIL clear_store_writes: got %0d want 4", wr_a_q.size() - n0); end
    n_vec++; if (word !== 32'h1122_3344) begin n_bad++; $display("FAIL clear_store_ram: got %h want 11223344", word); end
    // Clear in IDLE delays acceptance by one cycle
    gm = 1'b0; lat = -1; val = 32'd0;
    @(negedge clk_in);
    request = 1'b1; load_or_store = 1'b0; mem_op = OP_LB; mem_addr = 32'h200; lsb_clear = 1'b1; t0 = cyc;
    @(negedge clk_in);
    lsb_clear = 1'b0;
    for (int i = 0; i < 40 && !gm; i++) begin
      @(negedge clk_in);
      if (mem_valid) begin gm = 1'b1; lat = cyc - t0; val = mem_val; end
    end
    request = 1'b0;
    idle(2);
    n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL clear_idle_latency: got %0d want 4", lat); end
    n_vec++; if (val !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL clear_idle_value: got %h want ffffff80", val); end
  endtask

  task automatic test_rdy;
    int t0; int lat; bit gm; logic [31:0] val;
    gm = 1'b0; lat = -1; val = 32'd0;
    @(negedge clk_in);
    rdy_in = 1'b0;
    request = 1'b1; load_or_store = 1'b0; mem_op = OP_LBU; mem_addr = 32'h200; t0 = cyc;
    repeat (3) @(negedge clk_in);
    rdy_in = 1'b1;
    for (int i = 0; i < 40 && !gm; i++) begin
      @(negedge clk_in);
      if (mem_valid) begin gm = 1'b1; lat = cyc - t0; val = mem_val; end
    end
    request = 1'b0;
    idle(2);
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL rdy_latency: got %0d want 6", lat); end
    n_vec++; if (val !== 32'h0000_0080) begin n_bad++; $display("FAIL rdy_value: got %h want 00000080", val); end
  endtask

  task automatic test_reset_mid;
    int t0; int lat; int mv0; int mv_rst; bit gm; logic [31:0] val;
    mv0 = mv_cnt; gm = 1'b0; lat = -1; val = 32'd0;
    @(negedge clk_in);
    request = 1'b1; load_or_store = 1'b0; mem_op = OP_LW; mem_addr = 32'h100;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    mv_rst = mv_cnt - mv0;
    n_vec++; if (mem_a !== 32'd0) begin n_bad++; $display("FAIL rst_mid_mem_a: got %h want 0", mem_a); end
    rst_in = 1'b1; t0 = cyc;
    for (int i = 0; i < 40 && !gm; i++) begin
      @(negedge clk_in);
      if (mem_valid) begin gm = 1'b1; lat = cyc - t0; val = mem_val; end
    end
    request = 1'b0;
    idle(4);
    n_vec++; if (mv_rst !== 0) begin n_bad++; $display("FAIL rst_mid_pulse: got %0d want 0", mv_rst); end
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL rst_mid_latency: got %0d want 6", lat); end
    n_vec++; if (val !== 32'h4433_2211) begin n_bad++; $display("FAIL rst_mid_value: got %h want 44332211", val); end
    n_vec++; if (mv_cnt - mv0 !== 1) begin n_bad++; $display("FAIL rst_mid_count: got %0d want 1", mv_cnt - mv0); end
  endtask

  task automatic test_exclusive;
    n_vec++; if (both_seen !== 1'b0) begin n_bad++; $display("FAIL valid_overlap: got %b want 0", both_seen); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    ram[12'h104] = 8'h78; ram[12'h105] = 8'h56; ram[12'h106] = 8'h34; ram[12'h107] = 8'h12;
    ram[12'h200] = 8'h80; ram[12'h202] = 8'h34; ram[12'h203] = 8'h92; ram[12'h204] = 8'h7F;
    ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;
    test_reset();
    test_lw();
    test_extend();
    test_store();
    test_priority();
    test_io_stall();
    test_clear();
    test_rdy();
    test_reset_mid();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
